decoder: RTL and testbench

//  Inverse of the coefficient packer. Accepts a stream of W-bit packed words, unpacks OUTPUT_W

---
 rtl/decoder.sv | 163 ++++++++++++++++
 tb/tb_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// Coefficient unpacker: packed words enter a SIPO bit buffer LSB-first, and each output
// handshake takes OUTPUT_W fields of LVL bits from the bottom and re-centres them to [0,Q).
module decoder #(
    parameter int OUTPUT_W = 4,
    parameter int COEFF_W  = 23,
    parameter int MAX_LVL  = 20,
    parameter int W        = 64,
    parameter int BUF_W    = 192
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [2:0]                  sec_lvl,
    input  logic [2:0]                  decode_mode,
    input  logic                        clear,
    input  logic [W-1:0]                din,
    input  logic                        valid_i,
    output logic                        ready_i,
    output logic [OUTPUT_W*COEFF_W-1:0] dout,
    output logic                        valid_o,
    input  logic                        ready_o
);

    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int LVL_W  = $clog2(MAX_LVL + 1);
    localparam logic [COEFF_W-1:0] Q        = COEFF_W'(8380417);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(BUF_W - W);
    localparam logic [FILL_W-1:0]  W_LEN    = FILL_W'(W);

    typedef enum logic [2:0] {
        MODE_T0 = 3'd0,
        MODE_T1 = 3'd1,
        MODE_S1 = 3'd2,
        MODE_S2 = 3'd3,
        MODE_W1 = 3'd4,
        MODE_Z  = 3'd5
    } mode_e;

    logic [BUF_W-1:0]              r_buf;
    logic [FILL_W-1:0]             r_fill;
    logic [OUTPUT_W*COEFF_W-1:0]   r_dout;
    logic                          r_valid;
    logic                          r_init;

    logic                          w_sec_ok;
    logic [LVL_W-1:0]              w_lvl;
    logic                          w_sub;
    logic [COEFF_W-1:0]            w_off;
    logic [COEFF_W-1:0]            w_mask;
    logic [COEFF_W-1:0]            w_x;
    logic [FILL_W-1:0]             w_need;
    logic [FILL_W-1:0]             w_shift;
    logic [FILL_W-1:0]             w_pos;
    logic [FILL_W-1:0]             w_fill_nxt;
    logic                          w_accept;
    logic                          w_append;
    logic                          w_load;
    logic [BUF_W-1:0]              w_buf_nxt;
    logic [OUTPUT_W*COEFF_W-1:0]   w_coeffs;

    assign w_sec_ok = (sec_lvl == 3'd2) || (sec_lvl == 3'd3) || (sec_lvl == 3'd5);

    // Field width and re-centring offset; unsupported combinations give LVL=0.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        w_lvl = '0;
        w_sub = 1'b0;
        w_off = '0;
        if (w_sec_ok) begin
            case (mode_e'(decode_mode))
                MODE_T0: begin
                    w_lvl = LVL_W'(13);
                    w_sub = 1'b1;
                    w_off = COEFF_W'(4096);
                end
                MODE_T1: w_lvl = LVL_W'(10);
                MODE_S1, MODE_S2: begin
                    w_sub = 1'b1;
                    if (sec_lvl == 3'd3) begin
                        w_lvl = LVL_W'(4);
                        w_off = COEFF_W'(4);
                    end else begin
                        w_lvl = LVL_W'(3);
                        w_off = COEFF_W'(2);
                    end
                end
                MODE_W1: w_lvl = (sec_lvl == 3'd2) ? LVL_W'(6) : LVL_W'(4);
                MODE_Z: begin
                    w_sub = 1'b1;
                    if (sec_lvl == 3'd2) begin
                        w_lvl = LVL_W'(18);
                        w_off = COEFF_W'(1 << 17);
                    end else begin
                        w_lvl = LVL_W'(20);
                        w_off = COEFF_W'(1 << 19);
                    end
                end
                default: w_lvl = '0;
            endcase
        end
    end

    assign w_need   = FILL_W'(int'(w_lvl) * OUTPUT_W);
    assign w_mask   = (COEFF_W'(1) << w_lvl) - COEFF_W'(1);
    assign ready_i  = r_init && (r_fill <= FILL_MAX);

    assign w_accept = valid_i && ready_i && !clear;
    // With LVL=0 input is swallowed without buffering so the stream never stalls.
    assign w_append = w_accept && (w_lvl != '0);
    assign w_load   = !clear && (w_lvl != '0) && (!r_valid || ready_o) && (r_fill >= w_need);

    // The consume shift happens first, so a same-cycle append lands at fill_len - need.
    assign w_shift    = w_load ? w_need : '0;
    assign w_pos      = r_fill - w_shift;
    assign w_buf_nxt  = (r_buf >> w_shift)
                      | (w_append ? ({{(BUF_W-W){1'b0}}, din} << w_pos) : '0);
    assign w_fill_nxt = w_pos + (w_append ? W_LEN : '0);

    always_comb begin
        w_coeffs = '0;
        w_x      = '0;
        for (int i = 0; i < OUTPUT_W; i++) begin
            w_x = COEFF_W'(r_buf >> (i * int'(w_lvl))) & w_mask;
            if (!w_sub)
                w_coeffs[i*COEFF_W +: COEFF_W] = w_x;
            else if (w_x > w_off)
                w_coeffs[i*COEFF_W +: COEFF_W] = Q - (w_x - w_off);
            else
                w_coeffs[i*COEFF_W +: COEFF_W] = w_off - w_x;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer is plain flops rather than a RAM, so it is safe to reset it.
            r_buf   <= '0;
            r_fill  <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_init  <= 1'b0;
        end else begin
            r_init <= 1'b1;
            if (clear) begin
                r_buf   <= '0;
                r_fill  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_buf  <= w_buf_nxt;
                r_fill <= w_fill_nxt;
                if (w_load) begin
                    r_dout  <= w_coeffs;
                    r_valid <= 1'b1;
                end else if (r_valid && ready_o) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign dout    = r_dout;
    assign valid_o = r_valid;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: random packed words scored against a bit-queue model
// of the unpacking rules, plus directed vectors, backpressure, clear and async reset.
module tb_decoder;

    localparam int OUTPUT_W = 4;
    localparam int COEFF_W  = 23;
    localparam int W        = 64;
    localparam int OW       = OUTPUT_W * COEFF_W;
    localparam int Q        = 8380417;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    sec_lvl;
    logic [2:0]    decode_mode;
    logic          clear;
    logic [W-1:0]  din;
    logic          valid_i;
    logic          ready_i;
    logic [OW-1:0] dout;
    logic          valid_o;
    logic          ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    int          ready_ctl = 1;     // 0 hold low, 1 hold high, 2 random
    bit          mon_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [OW-1:0] prev_dout;
    bit          model_bits[$];
    logic [OW-1:0] got_q[$];

    int          m_lvl;
    int          m_x;
    int          m_missing;
    logic [OW-1:0] m_exp;

    always #5 clk = ~clk;

    decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sec_lvl    (sec_lvl),
        .decode_mode(decode_mode),
        .clear      (clear),
        .din        (din),
        .valid_i    (valid_i),
        .ready_i    (ready_i),
        .dout       (dout),
        .valid_o    (valid_o),
        .ready_o    (ready_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic int lvl_of(input int s, input int m);
        if (!(s == 2 || s == 3 || s == 5)) return 0;
        case (m)
            0:       return 13;
            1:       return 10;
            2, 3:    return (s == 3) ? 4 : 3;
            4:       return (s == 2) ? 6 : 4;
            5:       return (s == 2) ? 18 : 20;
            default: return 0;
        endcase
    endfunction

    function automatic int recentre(input int s, input int m, input int x);
        int v;
        case (m)
            0:       v = 4096 - x;
            2, 3:    v = ((s == 3) ? 4 : 2) - x;
            5:       v = ((s == 2) ? (1 << 17) : (1 << 19)) - x;
            default: return x;
        endcase
        if (v < 0) v += Q;
        return v;
    endfunction

    // Scoreboard: bits enter on input handshakes, and each output handshake consumes the next 4*LVL bits.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", 128'(valid_o), 128'(1));
                check("hold_dout", 128'(dout), 128'(prev_dout));
            end
            if (clear) begin
                model_bits.delete();
            end else begin
                m_lvl = lvl_of(int'(sec_lvl), int'(decode_mode));
                if (valid_o && ready_o) begin
                    m_exp     = '0;
                    m_missing = 0;
                    for (int i = 0; i < OUTPUT_W; i++) begin
                        m_x = 0;
                        for (int b = 0; b < m_lvl; b++) begin
                            if (model_bits.size() == 0) m_missing = 1;
                            else m_x |= int'(model_bits.pop_front()) << b;
                        end
                        m_exp[i*COEFF_W +: COEFF_W] =
                            COEFF_W'(recentre(int'(sec_lvl), int'(decode_mode), m_x));
                    end
                    check("dout_bits_avail", 128'(m_missing), 128'(0));
                    check("dout", 128'(dout), 128'(m_exp));
                    got_q.push_back(dout);
                end
                if (valid_i && ready_i && m_lvl != 0)
                    for (int b = 0; b < W; b++) model_bits.push_back(din[b]);
            end
            prev_stall = valid_o && !ready_o && !clear;
            prev_dout  = dout;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_ctl)
                0:       ready_o = 1'b0;
                1:       ready_o = 1'b1;
                default: ready_o = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end at posedge+1.
    task automatic send_word(input logic [W-1:0] w, input int gap);
        bit done;
        done = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        din     = w;
        valid_i = 1'b1;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (ready_i) done = 1'b1;
        end
        check("accept_in_time", 128'(done), 128'(1));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        for (int t = 0; t < 3000 && got_q.size() < n; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check(tag, 128'(got_q.size()), 128'(n));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cycle(input int s, input int m);
        int saved;
        saved       = ready_ctl;
        ready_ctl   = 0;
        valid_i     = 1'b0;
        clear       = 1'b1;
        sec_lvl     = 3'(s);
        decode_mode = 3'(m);
        @(posedge clk);
        #1;
        clear     = 1'b0;
        ready_ctl = saved;
        got_q.delete();
    endtask

    task automatic run_poly(input int s, input int m, input bit do_clear, input bit gaps);
        int n;
        if (do_clear) clear_cycle(s, m);
        got_q.delete();
        n = 4 * lvl_of(s, m);
        for (int k = 0; k < n; k++)
            send_word({$urandom(), $urandom()}, gaps ? $urandom_range(0, 2) : 0);
        drain(64, "poly_out_count");
        check("poly_bits_left", 128'(model_bits.size()), 128'(0));
    endtask

    logic [127:0] v;
    bit           saw_full;
    int           sl[3] = '{2, 3, 5};

    initial begin
        rst_n       = 1'b0;
        sec_lvl     = 3'd2;
        decode_mode = 3'd0;
        clear       = 1'b0;
        din         = '0;
        valid_i     = 1'b0;
        ready_o     = 1'b1;
        #3;
        check("reset_valid_o", 128'(valid_o), 128'(0));
        check("reset_dout", 128'(dout), 128'(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 128'(ready_i), 128'(1));
        mon_en = 1'b1;

        // lvl3 Z: fields 0, 0x80000, 0xFFFFF, 1
        clear_cycle(3, 5);
        v = '0;
        v |= 128'(20'h80000) << 20;
        v |= 128'(20'hFFFFF) << 40;
        v |= 128'(1) << 60;
        send_word(v[63:0], 0);
        send_word(v[127:64], 0);
        drain(1, "z_count");
        check("z_vector", 128'(got_q[0]), 128'({23'd524287, 23'd7856130, 23'd0, 23'd524288}));

        // T0: fields 0, 8191, 0, 8191
        clear_cycle(2, 0);
        v = (128'(8191) << 13) | (128'(8191) << 39);
        send_word(v[63:0], 0);
        drain(1, "t0_count");
        check("t0_vector", 128'(got_q[0]), 128'({23'd8376322, 23'd4096, 23'd8376322, 23'd4096}));

        // T1: fields 1023, 0, 1023, 5
        clear_cycle(2, 1);
        v = 128'(1023) | (128'(1023) << 20) | (128'(5) << 30);
        send_word(v[63:0], 0);
        drain(1, "t1_count");
        check("t1_vector", 128'(got_q[0]), 128'({23'd5, 23'd1023, 23'd0, 23'd1023}));

        // lvl2 S1: all-zero word gives 2s, then a word of 3-bit fields of 3 gives Q-1
        clear_cycle(2, 2);
        send_word(64'h0, 0);
        drain(5, "s1_zero_count");
        check("s1_zero_vector", 128'(got_q[0]), 128'({4{23'd2}}));
        clear_cycle(2, 2);
        v = '0;
        for (int k = 0; k < 21; k++) v |= 128'(3) << (3 * k);
        send_word(v[63:0], 0);
        drain(5, "s1_three_count");
        check("s1_three_vector", 128'(got_q[0]), 128'({4{23'd8380416}}));

        // Clear with 40 buffered bits (lvl2 Z, 4 words, 3 outputs), then lvl3 S1 from bit 0
        clear_cycle(2, 5);
        for (int k = 0; k < 4; k++) send_word({$urandom(), $urandom()}, 0);
        drain(3, "pre_clear_count");
        clear_cycle(3, 2);
        check("clear_valid_o", 128'(valid_o), 128'(0));
        send_word(64'h0000_0000_0000_4321, 0);
        drain(4, "post_clear_count");
        check("post_clear_vector", 128'(got_q[0]), 128'({23'd0, 23'd1, 23'd2, 23'd3}));

        // Unsupported combination: input absorbed, nothing emitted
        clear_cycle(4, 0);
        for (int k = 0; k < 6; k++) send_word({$urandom(), $urandom()}, 0);
        repeat (4) @(posedge clk);
        #1;
        check("lvl0_no_output", 128'(got_q.size()), 128'(0));
        check("lvl0_ready", 128'(ready_i), 128'(1));

        // Backpressure on a full T0 poly: 52 words -> 64 outputs
        clear_cycle(2, 0);
        ready_ctl = 0;
        saw_full  = 1'b0;
        fork
            begin
                for (int k = 0; k < 52; k++) send_word({$urandom(), $urandom()}, 0);
            end
            begin
                repeat (10) begin
                    @(negedge clk);
                    if (!ready_i) saw_full = 1'b1;
                end
                ready_ctl = 2;
            end
        join
        check("bp_ready_dropped", 128'(saw_full), 128'(1));
        drain(64, "bp_out_count");
        check("bp_bits_left", 128'(model_bits.size()), 128'(0));

        // Async reset mid-stream while an output is held
        clear_cycle(5, 5);
        ready_ctl = 0;
        send_word({$urandom(), $urandom()}, 0);
        send_word({$urandom(), $urandom()}, 0);
        for (int t = 0; t < 50 && !valid_o; t++) @(negedge clk);
        check("rst_pre_valid", 128'(valid_o), 128'(1));
        mon_en     = 1'b0;
        prev_stall = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 128'(valid_o), 128'(0));
        check("rst_async_dout", 128'(dout), 128'(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        model_bits.delete();
        got_q.delete();
        @(posedge clk);
        #1;
        check("rst_ready_after", 128'(ready_i), 128'(1));
        check("rst_valid_after", 128'(valid_o), 128'(0));
        ready_ctl = 2;
        mon_en    = 1'b1;
        run_poly(5, 5, 1'b0, 1'b1);

        // Random configurations, data, input gaps and output backpressure
        for (int p = 0; p < 8; p++)
            run_poly(sl[$urandom_range(0, 2)], $urandom_range(0, 5), 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
